// File: rtl/sobel_edge_detect.sv
// Sobel |Gx|+|Gy| edge detector on a 3x3 window stream, 3-cycle pipeline,
// binary RGB565 output with blanking of the incomplete-window border.
module sobel_edge_detect #(
  parameter logic [10:0] THRESHOLD = 11'd40,
  parameter int          COL_W     = 11,
  parameter int          ROW_W     = 10
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        frame_vsync,
  input  logic        process_href,
  input  logic        process_wrreq,
  input  logic [7:0]  matrix_p11,
  input  logic [7:0]  matrix_p12,
  input  logic [7:0]  matrix_p13,
  input  logic [7:0]  matrix_p21,
  input  logic [7:0]  matrix_p22,
  input  logic [7:0]  matrix_p23,
  input  logic [7:0]  matrix_p31,
  input  logic [7:0]  matrix_p32,
  input  logic [7:0]  matrix_p33,
  output logic        sobel_href,
  output logic        sobel_wrreq,
  output logic [15:0] sobel_wrdata
);

  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  // Reset asserts asynchronously, releases two clocks after s_rst falls
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) rst_sync_q <= 2'b11;
    else       rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst = rst_sync_q[1];

  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic             href_q;

  logic [9:0]  gx_p_d, gx_n_d, gy_p_d, gy_n_d;
  logic [9:0]  gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic        border_d;
  logic        border1_q, href1_q, wrreq1_q;

  logic [9:0]  gx_abs_d, gy_abs_d, gx_abs_q, gy_abs_q;
  logic        border2_q, href2_q, wrreq2_q;

  logic [10:0] sum_d;
  logic [15:0] wrdata_d, wrdata_q;
  logic        href3_q, wrreq3_q;

  always_comb begin
    col_cnt_d = col_cnt_q;
    if (!process_href)
      col_cnt_d = '0;
    else if (process_wrreq && (col_cnt_q != '1))
      col_cnt_d = col_cnt_q + COL_ONE;

    row_cnt_d = row_cnt_q;
    if (frame_vsync)
      row_cnt_d = '0;
    else if (href_q && !process_href && (row_cnt_q != '1))
      row_cnt_d = row_cnt_q + ROW_ONE;
  end

  always_comb begin
    gx_p_d   = {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
    gx_n_d   = {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
    gy_p_d   = {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
    gy_n_d   = {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
    border_d = (col_cnt_q < COL_W'(2)) || (row_cnt_q < ROW_W'(2));

    gx_abs_d = (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
    gy_abs_d = (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);

    sum_d    = {1'b0, gx_abs_q} + {1'b0, gy_abs_q};
    wrdata_d = (!border2_q && (sum_d > THRESHOLD)) ? 16'hFFFF : 16'h0000;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      href_q    <= 1'b0;
      gx_p_q    <= '0;
      gx_n_q    <= '0;
      gy_p_q    <= '0;
      gy_n_q    <= '0;
      border1_q <= 1'b0;
      href1_q   <= 1'b0;
      wrreq1_q  <= 1'b0;
      gx_abs_q  <= '0;
      gy_abs_q  <= '0;
      border2_q <= 1'b0;
      href2_q   <= 1'b0;
      wrreq2_q  <= 1'b0;
      wrdata_q  <= '0;
      href3_q   <= 1'b0;
      wrreq3_q  <= 1'b0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      href_q    <= process_href;
      gx_p_q    <= gx_p_d;
      gx_n_q    <= gx_n_d;
      gy_p_q    <= gy_p_d;
      gy_n_q    <= gy_n_d;
      border1_q <= border_d;
      href1_q   <= process_href;
      wrreq1_q  <= process_wrreq;
      gx_abs_q  <= gx_abs_d;
      gy_abs_q  <= gy_abs_d;
      border2_q <= border1_q;
      href2_q   <= href1_q;
      wrreq2_q  <= wrreq1_q;
      wrdata_q  <= wrdata_d;
      href3_q   <= href2_q;
      wrreq3_q  <= wrreq2_q;
    end
  end

  assign sobel_href   = href3_q;
  assign sobel_wrreq  = wrreq3_q;
  assign sobel_wrdata = wrdata_q;

endmodule

// File: tb/tb_sobel_edge_detect.sv
// Randomized + directed bench for sobel_edge_detect, checked against a
// behavioural per-pixel model and a 3-deep latency scoreboard.
module tb_sobel_edge_detect;

  logic        sclk = 1'b0;
  logic        s_rst = 1'b1;
  logic        vsync = 1'b0, href = 1'b0, wrreq = 1'b0;
  logic [7:0]  px [9];
  logic        sobel_href, sobel_wrreq;
  logic [15:0] sobel_wrdata;

  always #5 sclk = ~sclk;

  sobel_edge_detect dut (
    .sclk(sclk), .s_rst(s_rst), .frame_vsync(vsync),
    .process_href(href), .process_wrreq(wrreq),
    .matrix_p11(px[0]), .matrix_p12(px[1]), .matrix_p13(px[2]),
    .matrix_p21(px[3]), .matrix_p22(px[4]), .matrix_p23(px[5]),
    .matrix_p31(px[6]), .matrix_p32(px[7]), .matrix_p33(px[8]),
    .sobel_href(sobel_href), .sobel_wrreq(sobel_wrreq), .sobel_wrdata(sobel_wrdata)
  );

  typedef struct packed {
    logic        href;
    logic        wrreq;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   m_col, m_row;
  bit   m_href_prev;
  int   n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int pv(input int i);
    return int'(px[i]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One input cycle: model the pixel, advance one clock, compare the pixel from 3 clocks back
  task automatic step(input bit vs, input bit hr, input bit wr);
    exp_t e;
    int   gx, gy, sum;
    bit   border;
    vsync = vs; href = hr; wrreq = wr;
    border = (m_col < 2) || (m_row < 2);
    gx  = (pv(2) + 2*pv(5) + pv(8)) - (pv(0) + 2*pv(3) + pv(6));
    gy  = (pv(6) + 2*pv(7) + pv(8)) - (pv(0) + 2*pv(1) + pv(2));
    sum = iabs(gx) + iabs(gy);
    e.href  = hr;
    e.wrreq = wr;
    e.data  = (!border && sum > 40) ? 16'hFFFF : 16'h0000;
    q.push_back(e);
    if (!hr) m_col = 0;
    else if (wr && m_col < 2047) m_col++;
    if (vs) m_row = 0;
    else if (m_href_prev && !hr && m_row < 1023) m_row++;
    m_href_prev = hr;
    @(posedge sclk); #1;
    e = q.pop_front();
    chk("href",  {15'b0, sobel_href},  {15'b0, e.href});
    chk("wrreq", {15'b0, sobel_wrreq}, {15'b0, e.wrreq});
    if (e.wrreq) chk("wrdata", sobel_wrdata, e.data);
  endtask

  task automatic set_px(input int mode);
    int b, d;
    for (int i = 0; i < 9; i++) px[i] = 8'd0;
    case (mode)
      0: for (int i = 0; i < 9; i++) px[i] = 8'd100;
      1: begin
        px[0] = 0; px[3] = 0; px[6] = 0;
        px[2] = 255; px[5] = 255; px[8] = 255;
        px[1] = 128; px[4] = 128; px[7] = 128;
      end
      2: for (int i = 0; i < 9; i++) px[i] = 8'($urandom_range(0, 255));
      3: px[5] = 8'd20;
      4: px[5] = 8'd21;
      default: begin
        b = $urandom_range(0, 200);
        d = $urandom_range(17, 24);
        for (int i = 0; i < 9; i++) px[i] = 8'(b);
        px[5] = 8'(b + d);
      end
    endcase
  endtask

  // gap: 0 continuous, 1 alternating strobe, 2 random strobe
  task automatic row(input int n, input int mode, input int gap, input bit vs_at_end);
    bit wr;
    for (int i = 0; i < n; i++) begin
      set_px(mode);
      wr = (gap == 0) ? 1'b1 : (gap == 1) ? (i % 2 == 0) : ($urandom_range(0, 3) != 0);
      step(1'b0, 1'b1, wr);
    end
    set_px(1);
    step(vs_at_end, 1'b0, $urandom_range(0, 2) == 0);
  endtask

  task automatic do_reset();
    #2 s_rst = 1'b1;
    #1;
    chk("rst_href",   {15'b0, sobel_href},  16'h0);
    chk("rst_wrreq",  {15'b0, sobel_wrreq}, 16'h0);
    chk("rst_wrdata", sobel_wrdata,         16'h0);
    vsync = 1'b0; href = 1'b0; wrreq = 1'b0;
    repeat (2) @(posedge sclk);
    #3 s_rst = 1'b0;
    repeat (4) @(posedge sclk);
    #1;
    chk("idle_wrreq",  {15'b0, sobel_wrreq}, 16'h0);
    chk("idle_wrdata", sobel_wrdata,         16'h0);
    q.delete();
    q.push_back('0);
    q.push_back('0);
    m_col = 0; m_row = 0; m_href_prev = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 9; i++) px[i] = 8'd0;
    @(posedge sclk); #1;
    chk("por_href",   {15'b0, sobel_href},  16'h0);
    chk("por_wrreq",  {15'b0, sobel_wrreq}, 16'h0);
    chk("por_wrdata", sobel_wrdata,         16'h0);
    do_reset();

    // Border rows/cols, flat, threshold boundary, gapped strobe
    set_px(1); step(1'b1, 1'b0, 1'b0);
    row(6, 1, 0, 1'b0);
    row(6, 1, 0, 1'b0);
    row(6, 1, 0, 1'b0);
    row(6, 0, 0, 1'b0);
    row(5, 3, 0, 1'b0);
    row(5, 4, 0, 1'b0);
    row(12, 1, 1, 1'b0);
    row(12, 2, 2, 1'b0);
    // vsync coincident with href falling edge: row counter must restart
    row(6, 1, 0, 1'b1);
    row(5, 1, 0, 1'b0);
    row(5, 1, 0, 1'b0);
    row(5, 1, 0, 1'b0);

    // Reset in the middle of an edge row
    set_px(1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    do_reset();
    for (int r = 0; r < 3; r++) row(5, 1, 0, 1'b0);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      set_px(2); step(1'b1, 1'b0, $urandom_range(0, 1) == 1);
      for (int r = 0; r < 6; r++)
        row($urandom_range(3, 20), $urandom_range(0, 5), $urandom_range(0, 2), 1'b0);
    end

    // Column saturation: a wrap would re-blank the tail of the row
    set_px(1); step(1'b1, 1'b0, 1'b0);
    row(3, 1, 0, 1'b0);
    row(3, 1, 0, 1'b0);
    row(2060, 1, 0, 1'b0);

    // Row saturation: a wrap would re-blank rows past 1023
    for (int r = 0; r < 1030; r++) row(3, (r % 2 == 0) ? 1 : 5, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
